// File: rtl/rst_seq_pkg.sv
// Shared types and helpers for the sequenced reset release block.
// Optional feature macro used by the top: RST_SEQ_SWRST_EN (software restart request).
package rst_seq_pkg;

   // Sequencer states: waiting for the synchronizer, releasing channels, finished.
   typedef enum logic [1:0] {
      HOLD    = 2'd0,
      RELEASE = 2'd1,
      DONE    = 2'd2
   } state_e;

   // Width of the release counter: it must hold values 0 .. num_ch*dly_cyc.
   function automatic int cnt_width(input int num_ch, input int dly_cyc);
      int w;
      w = $clog2(num_ch * dly_cyc + 1);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/rst_sync_chain.sv
// Reset synchronizer: shifts a constant 1 through NUM_STAGES flops that are
// cleared asynchronously by reset, so sync_ok rises synchronously to clk.
module rst_sync_chain
   import rst_seq_pkg::*;
#(
   parameter int NUM_STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   output logic sync_ok
);

   logic [NUM_STAGES-1:0] stage_q;

   // Shift register of ones, cleared on reset assertion.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stage_q <= '0;
      end else begin
         stage_q <= {stage_q[NUM_STAGES-2:0], 1'b1};
      end
   end

   assign sync_ok = stage_q[NUM_STAGES-1];

endmodule

// File: rtl/rst_seq_sync.sv
// Sequenced reset release: after the asynchronous reset is synchronized,
// releases NUM_CH active-low channel resets one by one, DLY_CYC clocks apart,
// then raises rst_done together with the last channel.
// Optional macro RST_SEQ_SWRST_EN adds the synchronous sw_rst_req input that
// drops all channels and restarts the sequence without touching the synchronizer.
//
// Timing reference: T0 is the edge at which the sequence starts. On a cold
// start T0 is the edge at which sync_ok itself rises, which the FSM can only
// observe one edge later; the counter therefore tracks "edges elapsed since T0"
// and is loaded with 1 in that case. After a software restart sync_ok is
// already high, so the leaving edge is T0 itself and the counter loads 0.
module rst_seq_sync
   import rst_seq_pkg::*;
#(
   parameter int NUM_STAGES = 2,
   parameter int NUM_CH     = 3,
   parameter int DLY_CYC    = 4
) (
   input  logic              clk,
   input  logic              reset,
`ifdef RST_SEQ_SWRST_EN
   input  logic              sw_rst_req,
`endif
   output logic [NUM_CH-1:0] SYNC_RST,
   output logic              rst_done
);

   localparam int               CNT_W     = cnt_width(NUM_CH, DLY_CYC);
   localparam logic [CNT_W-1:0] CNT_TOTAL = CNT_W'(NUM_CH * DLY_CYC);

   logic              sync_ok;
   logic              sw_req_s;
   logic              cold_s;
   logic [CNT_W-1:0]  cnt_lead_s;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [NUM_CH-1:0] sync_rst_q, sync_rst_d;
   logic              rst_done_q, rst_done_d;

   rst_sync_chain #(
      .NUM_STAGES (NUM_STAGES)
   ) u_sync (
      .clk     (clk),
      .reset   (reset),
      .sync_ok (sync_ok)
   );

`ifdef RST_SEQ_SWRST_EN
   logic sw_prev_q;

   // Remember whether the previous edge carried a software request; if it did
   // not, a sync_ok seen now rose at that previous edge (cold start).
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sw_prev_q <= 1'b0;
      end else begin
         sw_prev_q <= sw_rst_req;
      end
   end

   assign sw_req_s = sw_rst_req;
   assign cold_s   = ~sw_prev_q;
`else
   assign sw_req_s = 1'b0;
   assign cold_s   = 1'b1;
`endif

   // Elapsed-edge count loaded when leaving HOLD: 1 on a cold start, 0 after a software restart.
   assign cnt_lead_s = CNT_W'(cold_s);

   // Next-state, counter and output computation for the release sequencer.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      sync_rst_d = sync_rst_q;
      rst_done_d = rst_done_q;

      if (sw_req_s) begin
         state_d    = HOLD;
         cnt_d      = '0;
         sync_rst_d = '0;
         rst_done_d = 1'b0;
      end else begin
         case (state_q)
            HOLD: begin
               if (sync_ok) begin
                  cnt_d   = cnt_lead_s;
                  state_d = (cnt_d == CNT_TOTAL) ? DONE : RELEASE;
               end else begin
                  cnt_d   = '0;
                  state_d = HOLD;
               end
            end
            RELEASE: begin
               if (cnt_q != CNT_TOTAL) begin
                  cnt_d = cnt_q + CNT_W'(1);
               end else begin
                  cnt_d = cnt_q;
               end
               state_d = (cnt_d == CNT_TOTAL) ? DONE : RELEASE;
            end
            DONE: begin
               cnt_d   = cnt_q;
               state_d = DONE;
            end
            default: begin
               cnt_d   = '0;
               state_d = HOLD;
            end
         endcase

         if (state_d != HOLD) begin
            // Channel k is released once DLY_CYC*(k+1) edges have elapsed since T0.
            for (int k = 0; k < NUM_CH; k++) begin
               sync_rst_d[k] = (cnt_d >= CNT_W'((k + 1) * DLY_CYC));
            end
            rst_done_d = (state_d == DONE);
         end else begin
            sync_rst_d = '0;
            rst_done_d = 1'b0;
         end
      end
   end

   // Sequencer state, counter and registered outputs, cleared asynchronously by reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= HOLD;
         cnt_q      <= '0;
         sync_rst_q <= '0;
         rst_done_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         sync_rst_q <= sync_rst_d;
         rst_done_q <= rst_done_d;
      end
   end

   assign SYNC_RST = sync_rst_q;
   assign rst_done = rst_done_q;

endmodule

// File: tb/tb_rst_seq_sync.sv
// Bench for rst_seq_sync: default instance (2/3/4) and minimal instance (3/1/1).
// The software-restart scenario runs only when RST_SEQ_SWRST_EN is defined.
module tb_rst_seq_sync;

   localparam int NS_A = 2;
   localparam int NC_A = 3;
   localparam int DL_A = 4;
   localparam int NS_B = 3;
   localparam int NC_B = 1;
   localparam int DL_B = 1;

   logic       clk   = 1'b0;
   logic       rst_a = 1'b0;
   logic       rst_b = 1'b0;
   logic       sw_a  = 1'b0;
`ifdef RST_SEQ_SWRST_EN
   logic       sw_b  = 1'b0;
`endif
   logic [2:0] sync_a;
   logic       done_a;
   logic [0:0] sync_b;
   logic       done_b;

   int total = 0;
   int bad   = 0;

   // Reference model state: edges since reset release, started flag, edges since T0.
   int fill_a = 0;
   int el_a   = 0;
   bit on_a   = 1'b0;
   int fill_b = 0;
   int el_b   = 0;
   bit on_b   = 1'b0;

   // Hand-computed literal expectations, {SYNC_RST, rst_done}.
   bit         lit_a_on = 1'b0;
   bit         lit_b_on = 1'b0;
   logic [3:0] lit_a_val = 4'b0000;
   logic [1:0] lit_b_val = 2'b00;
   string      lit_a_name = "";
   string      lit_b_name = "";

   logic [7:0] ea;
   logic [7:0] eb;
   logic       eda;
   logic       edb;

   always #5 clk = ~clk;

   rst_seq_sync #(.NUM_STAGES(NS_A), .NUM_CH(NC_A), .DLY_CYC(DL_A)) u_dut_a (
      .clk        (clk),
      .reset      (rst_a),
`ifdef RST_SEQ_SWRST_EN
      .sw_rst_req (sw_a),
`endif
      .SYNC_RST   (sync_a),
      .rst_done   (done_a)
   );

   rst_seq_sync #(.NUM_STAGES(NS_B), .NUM_CH(NC_B), .DLY_CYC(DL_B)) u_dut_b (
      .clk        (clk),
      .reset      (rst_b),
`ifdef RST_SEQ_SWRST_EN
      .sw_rst_req (sw_b),
`endif
      .SYNC_RST   (sync_b),
      .rst_done   (done_b)
   );

   // Expected channel vector: channel k released once (k+1)*d edges have passed since T0.
   function automatic logic [7:0] exp_sr(input bit on, input int el, input int n, input int d);
      logic [7:0] v;
      v = 8'h00;
      for (int k = 0; k < n; k++) begin
         v[k] = on && (el >= (k + 1) * d);
      end
      return v;
   endfunction

   // Model A: T0 is the first edge after which the synchronizer is full and no sw request was sampled.
   always @(posedge clk or negedge rst_a) begin
      if (!rst_a) begin
         fill_a <= 0;
         on_a   <= 1'b0;
         el_a   <= 0;
      end else begin
         fill_a <= (fill_a < 8) ? fill_a + 1 : fill_a;
         if (sw_a) begin
            on_a <= 1'b0;
            el_a <= 0;
         end else if (!on_a) begin
            if (fill_a + 1 >= NS_A) begin
               on_a <= 1'b1;
               el_a <= 0;
            end
         end else if (el_a < 1000) begin
            el_a <= el_a + 1;
         end
      end
   end

   // Model B: same rules for the minimal instance (no sw request).
   always @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         fill_b <= 0;
         on_b   <= 1'b0;
         el_b   <= 0;
      end else begin
         fill_b <= (fill_b < 8) ? fill_b + 1 : fill_b;
         if (!on_b) begin
            if (fill_b + 1 >= NS_B) begin
               on_b <= 1'b1;
               el_b <= 0;
            end
         end else if (el_b < 1000) begin
            el_b <= el_b + 1;
         end
      end
   end

   // Compare process: every falling clk edge and every reset assertion, 1 time unit later.
   always begin
      @(negedge clk or negedge rst_a or negedge rst_b);
      #1;
      ea  = exp_sr(on_a, el_a, NC_A, DL_A);
      eda = on_a && (el_a >= NC_A * DL_A);
      eb  = exp_sr(on_b, el_b, NC_B, DL_B);
      edb = on_b && (el_b >= NC_B * DL_B);
      total++;
      if ({5'b00000, sync_a} !== ea || done_a !== eda) begin
         bad++;
         $display("FAIL model_a t=%0t got sync=%b done=%b want sync=%b done=%b",
                  $time, sync_a, done_a, ea, eda);
      end
      total++;
      if ({7'b0000000, sync_b} !== eb || done_b !== edb) begin
         bad++;
         $display("FAIL model_b t=%0t got sync=%b done=%b want sync=%b done=%b",
                  $time, sync_b, done_b, eb, edb);
      end
      if (lit_a_on) begin
         total++;
         if ({sync_a, done_a} !== lit_a_val) begin
            bad++;
            $display("FAIL %s t=%0t got {sync,done}=%b want %b",
                     lit_a_name, $time, {sync_a, done_a}, lit_a_val);
         end
      end
      if (lit_b_on) begin
         total++;
         if ({sync_b, done_b} !== lit_b_val) begin
            bad++;
            $display("FAIL %s t=%0t got {sync,done}=%b want %b",
                     lit_b_name, $time, {sync_b, done_b}, lit_b_val);
         end
      end
   end

   task automatic lit_a(input string nm, input logic [3:0] v);
      lit_a_name = nm;
      lit_a_val  = v;
      lit_a_on   = 1'b1;
   endtask

   task automatic lit_b(input string nm, input logic [1:0] v);
      lit_b_name = nm;
      lit_b_val  = v;
      lit_b_on   = 1'b1;
   endtask

   task automatic lit_clear();
      lit_a_on = 1'b0;
      lit_b_on = 1'b0;
   endtask

   // Walk edges E1..last after a reset release, arming literal checks at key edges.
   task automatic run_seq(input bit with_b, input int last);
      for (int e = 1; e <= last; e++) begin
         @(posedge clk);
         #1;
         lit_clear();
         case (e)
            1:       lit_a("e1_held",     4'b0000);
            5:       lit_a("pre_ch0",     4'b0000);
            6:       lit_a("ch0_rise",    4'b0010);
            7:       lit_a("ch0_hold",    4'b0010);
            9:       lit_a("pre_ch1",     4'b0010);
            10:      lit_a("ch1_rise",    4'b0110);
            13:      lit_a("pre_done",    4'b0110);
            14:      lit_a("all_done",    4'b1111);
            16:      lit_a("done_static", 4'b1111);
            default: ;
         endcase
         if (with_b) begin
            case (e)
               3:       lit_b("min_t0",     2'b00);
               4:       lit_b("min_rise",   2'b11);
               8:       lit_b("min_static", 2'b11);
               default: ;
            endcase
         end
      end
      @(negedge clk);
      #2;
      lit_clear();
   endtask

   initial begin
      // Reset state with reset held low.
      lit_a("reset_state_a", 4'b0000);
      lit_b("reset_state_b", 2'b00);
      @(posedge clk);
      @(posedge clk);
      #1;
      lit_clear();
      #1;
      rst_a = 1'b1;
      rst_b = 1'b1;

      // Plain release on both instances.
      run_seq(1'b1, 16);

      // Mid-sequence reset: drop reset between E7 and E8, then full restart.
      rst_a = 1'b0;
      run_seq(1'b0, 0);
      rst_a = 1'b1;
      run_seq(1'b0, 7);
      lit_a("mid_rst_clear", 4'b0000);
      rst_a = 1'b0;
      @(posedge clk);
      #1;
      lit_clear();
      @(posedge clk);
      #2;
      rst_a = 1'b1;
      run_seq(1'b0, 16);

      // Short glitch in DONE: 3 time units (0.3 clk period) low.
      @(posedge clk);
      #1;
      lit_a("glitch_clear", 4'b0000);
      rst_a = 1'b0;
      #3;
      rst_a = 1'b1;
`ifdef RST_SEQ_SWRST_EN
      run_seq(1'b0, 19);
      // Software restart: request sampled at E20, E21, E22.
      sw_a = 1'b1;
      for (int e = 20; e <= 36; e++) begin
         @(posedge clk);
         #1;
         lit_clear();
         if (e == 22) begin
            sw_a = 1'b0;
         end
         case (e)
            20:      lit_a("sw_clear",    4'b0000);
            22:      lit_a("sw_held",     4'b0000);
            23:      lit_a("sw_t0",       4'b0000);
            26:      lit_a("sw_pre_ch0",  4'b0000);
            27:      lit_a("sw_ch0",      4'b0010);
            31:      lit_a("sw_ch1",      4'b0110);
            34:      lit_a("sw_pre_done", 4'b0110);
            35:      lit_a("sw_done",     4'b1111);
            default: ;
         endcase
      end
      @(negedge clk);
      #2;
      lit_clear();
`else
      run_seq(1'b0, 16);
`endif

      repeat (3) @(posedge clk);
      #2;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/rst_seq_sync.md
RST_SEQ_SYNC -- requirements
Module: rst_seq_sync

Interface
REQ-001 The block SHALL have parameter NUM_STAGES, default 2, which sets the synchronizer flop depth (legal range 2..4).
REQ-002 The block SHALL have parameter NUM_CH, default 3, which sets the number of sequenced reset outputs (legal range 1..8).
REQ-003 The block SHALL have parameter DLY_CYC, default 4, which sets the clk cycles between successive channel releases (legal range 1..255).
REQ-004 Port clk SHALL be an input, 1 bit wide: the single clock; all flops use its rising edge.
REQ-005 Port reset SHALL be an input, 1 bit wide: the asynchronous, active-low reset.
REQ-006 Port SYNC_RST SHALL be an output, NUM_CH bits wide: active-low per-channel resets, deasserted synchronously to clk.
REQ-007 Port rst_done SHALL be an output, 1 bit wide: high once every channel is released.
REQ-008 Port sw_rst_req SHALL be an input, 1 bit wide, synchronous to clk, active-high, and SHALL exist only when RST_SEQ_SWRST_EN is defined.

Function
REQ-009 The block SHALL pass constant 1 through a NUM_STAGES-deep flop chain cleared by reset; the last stage is sync_ok.
REQ-010 The FSM SHALL have states HOLD, RELEASE and DONE.
REQ-011 HOLD SHALL go to RELEASE at the first edge T0 where sync_ok=1; at T0 the counter SHALL load 1.
REQ-012 In RELEASE the counter SHALL increment by 1 per edge, with width $clog2(NUM_CH*DLY_CYC+1) and no wrap.
REQ-013 SYNC_RST[k] SHALL go 1 at edge T0+(k+1)*DLY_CYC and SHALL stay 1 until the next reset; channels release in ascending index order only.
REQ-014 At edge T0+NUM_CH*DLY_CYC the FSM SHALL enter DONE, and rst_done SHALL go 1 at that same edge, coincident with SYNC_RST[NUM_CH-1].
REQ-015 In DONE the counter SHALL hold and the outputs SHALL stay static.
REQ-016 All outputs SHALL be registered; no combinational path from reset deassertion to any output.
REQ-017 With NUM_CH=1 and DLY_CYC=1, SYNC_RST[0] and rst_done SHALL rise at T0+1.

Reset
REQ-018 Falling reset SHALL asynchronously clear, in any state: the sync chain, counter, FSM (to HOLD), SYNC_RST (to all 0) and rst_done (to 0).
REQ-019 Reset asserted mid-RELEASE SHALL discard progress; after the next deassertion the sequence SHALL restart from HOLD with full timing.
REQ-020 A reset pulse shorter than one clk period SHALL still clear all state and SHALL restart the full sequence.

Configuration
REQ-021 When RST_SEQ_SWRST_EN is defined, sw_rst_req=1 sampled at any edge SHALL, at that edge, clear SYNC_RST to 0, rst_done to 0 and the counter, and SHALL move the FSM to HOLD; the sync chain is untouched.
REQ-022 When RST_SEQ_SWRST_EN is defined, HOLD SHALL leave only at the first edge with sw_rst_req=0 and sync_ok=1; that edge is the new T0.
REQ-023 When RST_SEQ_SWRST_EN is defined and async reset and sw_rst_req are both active, async reset SHALL take priority.
REQ-024 When RST_SEQ_SWRST_EN is undefined, the sw_rst_req port and its logic SHALL be absent, and behaviour SHALL be identical to the macro-defined build with sw_rst_req tied 0.

Structure
REQ-025 Package rst_seq_pkg SHALL hold the FSM state enum (HOLD, RELEASE, DONE) and a count-width constant function.
REQ-026 The synchronizer chain SHALL be the sub-module rst_sync_chain (parameter NUM_STAGES, ports clk, reset, sync_ok).

Verification (defaults 2/3/4; E1 = first clk edge after reset rises)
REQ-027 Bench SHALL cover plain release: reset rises before E1 -> sync_ok=1 at E2 (T0=E2); SYNC_RST rises 001 at E6, 011 at E10, 111 at E14; rst_done=1 at E14.
REQ-028 Bench SHALL cover mid-sequence reset: reset falls between E7 and E8 -> SYNC_RST=000 and rst_done=0 immediately; after re-release, timing repeats exactly per REQ-027.
REQ-029 Bench SHALL cover a glitch: a 0.3-period reset pulse in DONE -> all outputs go 0 at once; full sequence restarts with T0 two edges after release.
REQ-030 Bench SHALL cover the software request: build with RST_SEQ_SWRST_EN, sw_rst_req high for edges E20..E22 in DONE -> outputs 000 at E20; T0=E23; 001 at E27, 011 at E31, 111 at E35.
REQ-031 Bench SHALL cover the minimal build: NUM_CH=1, DLY_CYC=1, NUM_STAGES=3 -> T0=E3; SYNC_RST[0] and rst_done rise at E4.
